ballot_collector: RTL and testbench
===================================

BALLOT_COLLECTOR -- requirements
Module: ballot_collector

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, default 255, the number of cycles after the first accepted ballot before a round is force-closed (range 1..65535).
REQ-002 SHALL provide port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL provide port vote_valid  input  1  ballot offered this cycle.
REQ-005 SHALL provide port vote_ready  output  1  collector can accept a ballot.
REQ-006 SHALL provide port vote_id  input  2  voter index 0..3.
REQ-007 SHALL provide port vote_val  input  1  ballot value: 1 = yes, 0 = no.
REQ-008 SHALL provide port res_valid  output  1  a closed-round result is presented.
REQ-009 SHALL provide port res_ready  input  1  consumer accepts the result.
REQ-010 SHALL provide port res_votes  output  4  packed ballots; bit n = voter n; missing voters read 0.
REQ-011 SHALL provide port res_class  output  3  one-hot class: [2] yes-count <= 1, [1] yes-count == 2, [0] yes-count >= 3.
REQ-012 SHALL provide port res_count  output  3  number of ballots received this round, 0..4.
REQ-013 SHALL provide port res_timeout  output  1  round closed by timeout, not by a full ballot set.
REQ-014 SHALL provide port dup_err  output  1  one-cycle pulse on a rejected duplicate ballot.

Function
REQ-015 SHALL implement two states, COLLECT and RESULT; vote_ready = 1 only in COLLECT, and res_valid = 1 only in RESULT.
REQ-016 SHALL accept a ballot when vote_valid && vote_ready, storing vote_val at bit vote_id and setting that voter's received flag.
REQ-017 SHALL discard a ballot whose voter flag is already set, leave the stored value unchanged, and pulse dup_err high for exactly the following cycle.
REQ-018 SHALL move COLLECT->RESULT on the edge that accepts the ballot completing the received mask 4'b1111; res_valid is high from the next cycle (1-cycle latency).
REQ-019 SHALL hold res_votes, res_class, res_count and res_timeout stable while res_valid = 1 && res_ready = 0.
REQ-020 SHALL, on res_valid && res_ready, clear the ballot store, the received mask and the timeout counter, and return to COLLECT on the same edge.
REQ-021 SHALL derive res_class from the popcount of res_votes, with exactly one bit set whenever res_valid = 1.
REQ-022 SHALL ignore vote_valid in RESULT: no store, no dup_err, and the ballot is held back by vote_ready = 0.

Reset
REQ-023 SHALL, while rst_n = 0, force state COLLECT, clear the store, mask and counter, and drive res_valid, dup_err and res_timeout to 0, res_votes to 4'b0000, res_class to 3'b000 and res_count to 0.
REQ-024 SHALL discard a partial round or an unconsumed result asserted mid-operation on reset, with no result emitted for it.

Configuration
REQ-025 SHALL compile the timeout feature under macro BALLOT_TIMEOUT_EN: when it is defined, the counter starts on the first accepted ballot and, after TIMEOUT_CYCLES cycles without completion, forces RESULT with res_timeout = 1 and missing ballots read as 0.
REQ-026 SHALL, with BALLOT_TIMEOUT_EN undefined, omit the counter, wait indefinitely in COLLECT, and tie res_timeout to 0.
REQ-027 SHALL treat a fourth ballot accepted on the expiry cycle as completion: res_timeout = 0 and res_count = 4.
REQ-028 SHALL never start the timeout counter in an empty round: no ballots means no result.

Structure
REQ-029 SHALL take from shared package ballot_pkg: N_VOTERS = 4, the state enum, and the res_class bit-index constants.
REQ-030 SHALL instantiate one combinational sub-module, vote_classifier, that maps 4 ballots to a popcount and a one-hot class.

Verification
REQ-031 SHALL check: ballots id0=1, id1=1, id2=0, id3=1 back-to-back -> res_valid one cycle after the 4th, res_votes = 4'b1011, res_class = 3'b001, res_count = 4.
REQ-032 SHALL check: ids 0,1 yes and ids 2,3 no, with res_ready held low for 5 cycles -> res_class = 3'b010, outputs stable, vote_ready = 0 throughout.
REQ-033 SHALL check: id2=1 then id2=0 -> dup_err pulses once, res_votes[2] stays 1, and the round completes normally afterwards.
REQ-034 SHALL check: with BALLOT_TIMEOUT_EN and TIMEOUT_CYCLES = 8, a single ballot id0=1 -> after 8 cycles res_timeout = 1, res_votes = 4'b0001, res_count = 1, res_class = 3'b100.
REQ-035 SHALL check: rst_n pulsed low asynchronously after 3 ballots -> all outputs return to reset values at once, and the next 4 ballots produce a clean result.
REQ-036 SHALL check: a 4th ballot on the exact timeout-expiry cycle -> res_timeout = 0 and res_count = 4.

Source files
------------

// File: rtl/ballot_pkg.sv
// Shared types and constants for the ballot collector slice.
package ballot_pkg;

   localparam int unsigned N_VOTERS = 4;
   localparam int unsigned ID_W     = 2;
   localparam int unsigned CNT_W    = 3;
   localparam int unsigned CLASS_W  = 3;
   localparam int unsigned TMR_W    = 16;

   // res_class bit positions
   localparam int unsigned CLASS_LOW  = 2;
   localparam int unsigned CLASS_TIE  = 1;
   localparam int unsigned CLASS_HIGH = 0;

   typedef enum logic {
      COLLECT = 1'b0,
      RESULT  = 1'b1
   } state_t;

   typedef struct packed {
      logic [N_VOTERS-1:0] votes;
      logic [CLASS_W-1:0]  cls;
      logic [CNT_W-1:0]    count;
      logic                timeout;
   } result_t;

   function automatic logic [CNT_W-1:0] popcount(input logic [N_VOTERS-1:0] v);
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < int'(N_VOTERS); i++) c = c + CNT_W'(v[i]);
      return c;
   endfunction

endpackage

// File: rtl/vote_classifier.sv
// Combinational: ballots received count and one-hot yes-count class.
module vote_classifier
   import ballot_pkg::*;
(
   input  logic [N_VOTERS-1:0] votes,
   input  logic [N_VOTERS-1:0] mask,
   output logic [CNT_W-1:0]    count,
   output logic [CLASS_W-1:0]  vote_class
);

   logic [CNT_W-1:0] yes;

   always_comb begin
      yes        = popcount(votes);
      count      = popcount(mask);
      vote_class = '0;
      if (yes <= CNT_W'(1))      vote_class[CLASS_LOW]  = 1'b1;
      else if (yes == CNT_W'(2)) vote_class[CLASS_TIE]  = 1'b1;
      else                       vote_class[CLASS_HIGH] = 1'b1;
   end

endmodule

// File: rtl/ballot_collector.sv
// Collects one ballot per voter, then presents a classified result.
// Optional force-close timeout compiled in with BALLOT_TIMEOUT_EN.
module ballot_collector
   import ballot_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                vote_valid,
   output logic                vote_ready,
   input  logic [ID_W-1:0]     vote_id,
   input  logic                vote_val,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [N_VOTERS-1:0] res_votes,
   output logic [CLASS_W-1:0]  res_class,
   output logic [CNT_W-1:0]    res_count,
   output logic                res_timeout,
   output logic                dup_err
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
      $error("ballot_collector: TIMEOUT_CYCLES out of range 1..65535");
   end

   state_t              state, state_next;
   logic [N_VOTERS-1:0] votes, votes_next;
   logic [N_VOTERS-1:0] mask, mask_next;
   logic                dup_next;
   logic                timeout_hit;
   result_t             res_q, res_d;
   logic [CNT_W-1:0]    cls_count;
   logic [CLASS_W-1:0]  cls_class;

`ifdef BALLOT_TIMEOUT_EN
   logic [TMR_W-1:0]    tmr, tmr_next;
`endif

   // Classify the post-edge ballot set so the result can be captured on the closing edge
   vote_classifier u_classifier (
      .votes      (votes_next),
      .mask       (mask_next),
      .count      (cls_count),
      .vote_class (cls_class)
   );

   always_comb begin
      state_next  = state;
      votes_next  = votes;
      mask_next   = mask;
      dup_next    = 1'b0;
      timeout_hit = 1'b0;
      res_d       = res_q;
`ifdef BALLOT_TIMEOUT_EN
      tmr_next    = tmr;
`endif
      case (state)
         COLLECT: begin
            if (vote_valid && vote_ready) begin
               if (mask[vote_id]) begin
                  dup_next = 1'b1;
               end else begin
                  votes_next[vote_id] = vote_val;
                  mask_next[vote_id]  = 1'b1;
               end
            end
`ifdef BALLOT_TIMEOUT_EN
            // Counter only runs once the round holds at least one ballot
            if (mask != '0) begin
               tmr_next    = tmr + TMR_W'(1);
               timeout_hit = (tmr == TMR_W'(TIMEOUT_CYCLES - 1));
            end
`endif
            if (mask_next == '1 || timeout_hit) begin
               state_next    = RESULT;
               res_d.votes   = votes_next;
               res_d.cls     = cls_class;
               res_d.count   = cls_count;
               res_d.timeout = (mask_next != '1);
            end
         end
         RESULT: begin
            if (res_ready) begin
               state_next = COLLECT;
               votes_next = '0;
               mask_next  = '0;
               res_d      = '0;
`ifdef BALLOT_TIMEOUT_EN
               tmr_next   = '0;
`endif
            end
         end
         default: state_next = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= COLLECT;
         votes      <= '0;
         mask       <= '0;
         res_q      <= '0;
         dup_err    <= 1'b0;
         res_valid  <= 1'b0;
         vote_ready <= 1'b1;
`ifdef BALLOT_TIMEOUT_EN
         tmr        <= '0;
`endif
      end else begin
         state      <= state_next;
         votes      <= votes_next;
         mask       <= mask_next;
         res_q      <= res_d;
         dup_err    <= dup_next;
         res_valid  <= (state_next == RESULT);
         vote_ready <= (state_next == COLLECT);
`ifdef BALLOT_TIMEOUT_EN
         tmr        <= tmr_next;
`endif
      end
   end

   assign res_votes   = res_q.votes;
   assign res_class   = res_q.cls;
   assign res_count   = res_q.count;
   assign res_timeout = res_q.timeout;

endmodule

// File: tb/tb_ballot_collector.sv
// Directed table-driven bench for ballot_collector plus multi-cycle corner sequences.
module tb_ballot_collector;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       vote_valid = 1'b0;
   logic       vote_ready;
   logic [1:0] vote_id = 2'd0;
   logic       vote_val = 1'b0;
   logic       res_valid;
   logic       res_ready = 1'b0;
   logic [3:0] res_votes;
   logic [2:0] res_class;
   logic [2:0] res_count;
   logic       res_timeout;
   logic       dup_err;

   int n_checks = 0;
   int n_fail   = 0;

   ballot_collector #(.TIMEOUT_CYCLES(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .vote_valid  (vote_valid),
      .vote_ready  (vote_ready),
      .vote_id     (vote_id),
      .vote_val    (vote_val),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_votes   (res_votes),
      .res_class   (res_class),
      .res_count   (res_count),
      .res_timeout (res_timeout),
      .dup_err     (dup_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       valid;
      logic [1:0] id;
      logic       val;
      logic       rdy;
      logic [13:0] exp;
   } vec_t;

   // Expected output bundle: {vote_ready, res_valid, votes, class, count, dup_err, timeout}
   function automatic logic [13:0] E(input logic vr, input logic rv, input logic [3:0] vt,
                                      input logic [2:0] cl, input logic [2:0] cn,
                                      input logic dp, input logic to);
      return {vr, rv, vt, cl, cn, dp, to};
   endfunction

   function automatic logic [13:0] obs();
      return {vote_ready, res_valid, res_votes, res_class, res_count, dup_err, res_timeout};
   endfunction

   task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got vr=%b rv=%b votes=%b cls=%b cnt=%0d dup=%b tout=%b, expected vr=%b rv=%b votes=%b cls=%b cnt=%0d dup=%b tout=%b",
                  name, act[13], act[12], act[11:8], act[7:5], act[4:2], act[1], act[0],
                  exp[13], exp[12], exp[11:8], exp[7:5], exp[4:2], exp[1], exp[0]);
      end
   endtask

   // Present inputs, clock once, sample 1 time unit after the edge
   task automatic drive(input logic valid, input logic [1:0] id, input logic val, input logic rdy);
      vote_valid = valid;
      vote_id    = id;
      vote_val   = val;
      res_ready  = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 1'b0, 1'b0);
   endtask

   vec_t        tbl[21];
   logic [13:0] idle_o;

   initial begin
      idle_o = E(1, 0, 4'b0000, 3'b000, 3'd0, 0, 0);

      // back-to-back 1,1,0,1
      tbl[0]  = '{1'b1, 2'd0, 1'b1, 1'b0, idle_o};
      tbl[1]  = '{1'b1, 2'd1, 1'b1, 1'b0, idle_o};
      tbl[2]  = '{1'b1, 2'd2, 1'b0, 1'b0, idle_o};
      tbl[3]  = '{1'b1, 2'd3, 1'b1, 1'b0, E(0, 1, 4'b1011, 3'b001, 3'd4, 0, 0)};
      tbl[4]  = '{1'b0, 2'd0, 1'b0, 1'b1, idle_o};
      // 2 yes / 2 no, consumer stalls 5 cycles while a ballot is offered
      tbl[5]  = '{1'b1, 2'd0, 1'b1, 1'b0, idle_o};
      tbl[6]  = '{1'b1, 2'd1, 1'b1, 1'b0, idle_o};
      tbl[7]  = '{1'b1, 2'd2, 1'b0, 1'b0, idle_o};
      tbl[8]  = '{1'b1, 2'd3, 1'b0, 1'b0, E(0, 1, 4'b0011, 3'b010, 3'd4, 0, 0)};
      for (int i = 9; i < 14; i++)
         tbl[i] = '{1'b1, 2'd0, 1'b0, 1'b0, E(0, 1, 4'b0011, 3'b010, 3'd4, 0, 0)};
      tbl[14] = '{1'b0, 2'd0, 1'b0, 1'b1, idle_o};
      // duplicate on id2 is dropped
      tbl[15] = '{1'b1, 2'd2, 1'b1, 1'b0, idle_o};
      tbl[16] = '{1'b1, 2'd2, 1'b0, 1'b0, E(1, 0, 4'b0000, 3'b000, 3'd0, 1, 0)};
      tbl[17] = '{1'b1, 2'd0, 1'b0, 1'b0, idle_o};
      tbl[18] = '{1'b1, 2'd1, 1'b0, 1'b0, idle_o};
      tbl[19] = '{1'b1, 2'd3, 1'b0, 1'b0, E(0, 1, 4'b0100, 3'b100, 3'd4, 0, 0)};
      tbl[20] = '{1'b0, 2'd0, 1'b0, 1'b1, idle_o};

      @(posedge clk);
      #1;
      check("reset_state", obs(), idle_o);
      rst_n = 1'b1;

      idle(20);
      check("empty_round_no_result", obs(), idle_o);

      for (int i = 0; i < 21; i++) begin
         drive(tbl[i].valid, tbl[i].id, tbl[i].val, tbl[i].rdy);
         check($sformatf("vec[%0d]", i), obs(), tbl[i].exp);
      end

      // asynchronous reset after three ballots
      drive(1, 2'd0, 1, 0);
      drive(1, 2'd1, 0, 0);
      drive(1, 2'd2, 1, 0);
      vote_valid = 1'b0;
      #3 rst_n = 1'b0;
      #1 check("async_reset_partial", obs(), idle_o);
      #2 rst_n = 1'b1;
      drive(1, 2'd0, 0, 0);
      drive(1, 2'd1, 0, 0);
      drive(1, 2'd2, 1, 0);
      check("post_reset_3rd", obs(), idle_o);
      drive(1, 2'd3, 1, 0);
      check("post_reset_result", obs(), E(0, 1, 4'b1100, 3'b010, 3'd4, 0, 0));

      // reset drops an unconsumed result
      vote_valid = 1'b0;
      #3 rst_n = 1'b0;
      #1 check("async_reset_result", obs(), idle_o);
      #2 rst_n = 1'b1;
      idle(12);
      check("dropped_result_stays_gone", obs(), idle_o);

`ifdef BALLOT_TIMEOUT_EN
      // single ballot force-closed after 8 cycles
      drive(1, 2'd0, 1, 0);
      idle(7);
      check("timeout_not_yet", obs(), idle_o);
      idle(1);
      check("timeout_fired", obs(), E(0, 1, 4'b0001, 3'b100, 3'd1, 0, 1));
      drive(0, 2'd0, 0, 1);
      check("timeout_consumed", obs(), idle_o);

      // fourth ballot on the expiry edge counts as completion
      drive(1, 2'd0, 1, 0);
      drive(1, 2'd1, 1, 0);
      drive(1, 2'd2, 1, 0);
      idle(5);
      check("expiry_edge_not_yet", obs(), idle_o);
      drive(1, 2'd3, 1, 0);
      check("expiry_edge_complete", obs(), E(0, 1, 4'b1111, 3'b001, 3'd4, 0, 0));
      drive(0, 2'd0, 0, 1);
      check("expiry_consumed", obs(), idle_o);
`else
      // without the timeout a partial round waits indefinitely
      drive(1, 2'd0, 1, 0);
      idle(300);
      check("no_timeout_waits", obs(), idle_o);
      drive(1, 2'd1, 1, 0);
      drive(1, 2'd2, 1, 0);
      drive(1, 2'd3, 1, 0);
      check("no_timeout_complete", obs(), E(0, 1, 4'b1111, 3'b001, 3'd4, 0, 0));
      drive(0, 2'd0, 0, 1);
      check("no_timeout_consumed", obs(), idle_o);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
